// File: rtl/us_delay_arbiter.sv
// us_delay_arbiter: four requesters share one microsecond prescaler and one
// delay down-counter. Grants are round-robin. After the granted delay has
// elapsed, the owner gets a single-cycle completion pulse.
// Optional feature: define US_DELAY_ARBITER_ABORT_EN to add the abort input
// and the aborted output.
module us_delay_arbiter #(
    parameter int unsigned CLK_PER_US = 20,
    parameter int unsigned DLY_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*DLY_W-1:0] dly_us,
`ifdef US_DELAY_ARBITER_ABORT_EN
    input  logic               abort,
    output logic               aborted,
`endif
    output logic [3:0]         ack,
    output logic [3:0]         done,
    output logic               busy,
    output logic [1:0]         owner,
    output logic               us_tick
);

    localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       ack_q, ack_d;
    logic [3:0]       done_q, done_d;
    logic             tick_q, tick_d;
`ifdef US_DELAY_ARBITER_ABORT_EN
    logic             aborted_q, aborted_d;
`endif

    logic             grant_valid;
    logic [1:0]       grant_idx;

    // Round-robin pick: the search starts at the requester after the last owner
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        for (int unsigned off = 1; off <= 4; off++) begin
            if (!grant_valid && req[last_q + off[1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = last_q + off[1:0];
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/COUNT/DONE sequence
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        ack_d     = '0;
        done_d    = '0;
        tick_d    = 1'b0;
`ifdef US_DELAY_ARBITER_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d          = COUNT;
                    cnt_d            = dly_us[grant_idx*DLY_W +: DLY_W];
                    pre_d            = '0;
                    owner_d          = grant_idx;
                    last_d           = grant_idx;
                    ack_d[grant_idx] = 1'b1;
                end
            end
            COUNT: begin
`ifdef US_DELAY_ARBITER_ABORT_EN
                if (abort) begin
                    state_d         = DONE;
                    done_d[owner_q] = 1'b1;
                    aborted_d       = 1'b1;
                end else
`endif
                if (cnt_q == '0) begin
                    state_d         = DONE;
                    done_d[owner_q] = 1'b1;
                end else if (pre_q == PRE_LAST) begin
                    pre_d  = '0;
                    cnt_d  = cnt_q - 1'b1;
                    tick_d = 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            cnt_q     <= '0;
            owner_q   <= 2'd0;
            last_q    <= 2'd3;
            ack_q     <= '0;
            done_q    <= '0;
            tick_q    <= 1'b0;
`ifdef US_DELAY_ARBITER_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            tick_q    <= tick_d;
`ifdef US_DELAY_ARBITER_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign us_tick = tick_q;
    assign owner   = owner_q;
    assign busy    = (state_q != IDLE);
`ifdef US_DELAY_ARBITER_ABORT_EN
    assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_us_delay_arbiter.sv
// Testbench for us_delay_arbiter. A transaction-level model predicts the
// outputs: each grant gives an ack cycle k and an end cycle of k+dly*20+1.
// Directed phases run first, then randomized traffic follows.
module tb_us_delay_arbiter;

    localparam int unsigned CPU   = 20;
    localparam int unsigned DLY_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3:0]         req = '0;
    logic [4*DLY_W-1:0] dly_us = '0;
    logic               abort_i = 1'b0;
    logic [3:0]         ack, done;
    logic               busy, us_tick;
    logic [1:0]         owner;
`ifdef US_DELAY_ARBITER_ABORT_EN
    logic               aborted;
`endif

    us_delay_arbiter #(.CLK_PER_US(CPU), .DLY_W(DLY_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .dly_us  (dly_us),
`ifdef US_DELAY_ARBITER_ABORT_EN
        .abort   (abort_i),
        .aborted (aborted),
`endif
        .ack     (ack),
        .done    (done),
        .busy    (busy),
        .owner   (owner),
        .us_tick (us_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Model state: one active delay, described by its ack and end cycles
    bit m_active = 0;
    bit m_ab     = 0;
    int m_k = 0, m_end = 0, m_dly = 0;
    int m_owner = 0, m_last = 3;

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        int cyc;
        logic [3:0] e_ack, e_done;
        logic e_busy, e_tick, e_ab;
        int r;
        for (cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            // drive the inputs sampled at the coming posedge
            abort_i = 1'b0;
            rst     = 1'b0;
            if (cyc < 2) begin
                rst = 1'b1; req = '0;
            end else if (cyc < 140) begin
                req = 4'b0001; dly_us = {4{8'd3}};
            end else if (cyc < 300) begin
                req = 4'b1111; dly_us = {4{8'd1}};
            end else if (cyc < 360) begin
                req = 4'b0011;
                dly_us = {8'd0, 8'd0, ($urandom_range(0, 1) ? 8'd2 : 8'd7), 8'd3};
                rst = (cyc == 335);
            end else if (cyc < 420) begin
                req = 4'b0100; dly_us = {4{8'd0}};
            end else begin
                r = $urandom_range(0, 99);
                req = (r < 30) ? 4'b0000 : 4'($urandom);
                for (int i = 0; i < 4; i++)
                    dly_us[i*DLY_W +: DLY_W] = 8'($urandom_range(0, 3) == 0 ? $urandom_range(4, 6) : $urandom_range(0, 2));
                rst = ($urandom_range(0, 399) == 0);
`ifdef US_DELAY_ARBITER_ABORT_EN
                abort_i = ($urandom_range(0, 29) == 0);
`endif
            end
            if (cyc == 100) begin
`ifdef US_DELAY_ARBITER_ABORT_EN
                abort_i = 1'b1;
`endif
            end

            // expected outputs for this cycle
            e_ack = '0; e_done = '0; e_busy = 1'b0; e_tick = 1'b0; e_ab = 1'b0;
            if (m_active) begin
                e_busy = 1'b1;
                if (cyc == m_k) e_ack = onehot(m_owner);
                if (cyc == m_end) begin
                    e_done = onehot(m_owner);
                    e_ab   = m_ab;
                end
                if (cyc > m_k && cyc < m_end && ((cyc - m_k) % CPU) == 0) e_tick = 1'b1;
            end
            check("ack", 32'(ack), 32'(e_ack));
            check("done", 32'(done), 32'(e_done));
            check("busy", 32'(busy), 32'(e_busy));
            check("us_tick", 32'(us_tick), 32'(e_tick));
            check("owner", 32'(owner), 32'(m_owner));
`ifdef US_DELAY_ARBITER_ABORT_EN
            check("aborted", 32'(aborted), 32'(e_ab));
`else
            if (e_ab) check("aborted_model", 32'(e_ab), 32'(0));
`endif

            // advance the model with the inputs seen at this edge
            if (rst) begin
                m_active = 0; m_owner = 0; m_last = 3; m_ab = 0;
            end else if (m_active) begin
                if (abort_i && cyc < m_end) begin
`ifdef US_DELAY_ARBITER_ABORT_EN
                    m_end = cyc + 1;
                    m_ab  = 1;
`endif
                end
                if (cyc == m_end) m_active = 0;
            end else if (req != 4'b0000) begin
                for (int off = 1; off <= 4; off++) begin
                    if (!m_active && req[(m_last + off) % 4]) begin
                        m_owner  = (m_last + off) % 4;
                        m_active = 1;
                    end
                end
                m_last = m_owner;
                m_dly  = int'(dly_us[m_owner*DLY_W +: DLY_W]);
                m_k    = cyc + 1;
                m_end  = m_k + m_dly * CPU + 1;
                m_ab   = 0;
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/us_delay_arbiter.md
US_DELAY_ARBITER -- requirements
Module: us_delay_arbiter

Interface
REQ-001 Parameters:
- CLK_PER_US, 20, clk cycles per microsecond tick.
- DLY_W, 8, width of each delay request in microseconds.
REQ-002 Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- req  in  4  per-requester delay request, level.
- dly_us  in  4*DLY_W  requester i delay at bits [i*DLY_W +: DLY_W].
- ack  out  4  one-hot, one-cycle grant pulse.
- done  out  4  one-hot, one-cycle completion pulse.
- busy  out  1  high while a delay is owned.
- owner  out  2  index of current or last granted requester.
- us_tick  out  1  one-cycle pulse each elapsed microsecond of an active delay.
REQ-003 The clock is clk; the reset is rst, synchronous and active-high; no other clock or reset exists.

Function
REQ-004 The block SHALL share one prescaler (0..CLK_PER_US-1) and one DLY_W-bit down-counter among 4 requesters.
REQ-005 FSM states SHALL be IDLE, COUNT and DONE; no other states are reachable.
REQ-006 IDLE: if any req is high at a clock edge, grant requester i and go to COUNT; otherwise stay in IDLE.
REQ-007 Arbitration SHALL be round-robin: search starts at (last_owner+1) mod 4; last_owner resets to 3, so requester 0 wins first.
REQ-008 On grant, the block SHALL latch dly_us[i] into the down-counter, clear the prescaler, set owner=i, and drive ack[i]=1 for exactly the first COUNT cycle.
REQ-009 COUNT: the prescaler increments each cycle; at CLK_PER_US-1 it wraps to 0, the down-counter decrements, and us_tick pulses.
REQ-010 COUNT SHALL exit to DONE in the cycle after the down-counter reaches 0; done[owner] is high for the single DONE cycle, then the FSM returns to IDLE.
REQ-011 Latency: with ack in cycle k, done SHALL be high in cycle k + dly*CLK_PER_US + 1.
REQ-012 dly=0: COUNT SHALL last one cycle with no us_tick, and done is in cycle k+1.
REQ-013 Once granted, req and dly_us of any requester SHALL be ignored until IDLE; a requester must hold req until its ack.
REQ-014 Requests arriving during COUNT/DONE SHALL be arbitrated in IDLE; the earliest next ack is 2 cycles after done.
REQ-015 busy SHALL be high in COUNT and DONE and low in IDLE.
REQ-016 ack, done and us_tick SHALL each be one-hot or zero and never asserted together in the same cycle for different requesters.

Reset
REQ-017 With rst high at an edge, the block SHALL enter IDLE, zero the counters and the outputs (owner=0), and set last_owner=3.
REQ-018 Reset asserted mid-COUNT SHALL abort the delay with no done pulse.

Configuration
REQ-019 Macro US_DELAY_ARBITER_ABORT_EN SHALL control the abort feature.
- Defined: adds input abort (1) and output aborted (1). abort high in COUNT forces DONE next cycle, with done[owner] and aborted both high for that cycle. abort is ignored in IDLE/DONE. aborted resets to 0.
- Undefined: no abort or aborted ports; delays run to completion.

Verification
REQ-020 Scenarios use CLK_PER_US=20.
- Single: req[0], dly=3 -> ack[0] cycle k; us_tick at k+20, k+40, k+60; done[0] at k+61.
- dly=0 on req[2] -> ack[2] at k, done[2] at k+1, no us_tick.
- Contention: req=4'b1111 held, each dly=1 -> ack order 0,1,2,3,0; each done 21 cycles after its ack; next ack 2 cycles after done.
- Mid-operation change: change req[1]/dly_us[1] during requester 0's COUNT -> done[0] timing unchanged.
- Reset at k+30 of a dly=3 delay -> no done, outputs zero; next grant goes to requester 0.
- ABORT_EN: abort at k+25 of dly=5 -> done and aborted at k+26; without the macro the bench verifies the delay completes at k+101.
